// File: rtl/hp_cvtws_seq_if.sv
// Handshake bundle for the bfloat16 -> signed integer converter.
// The master modport is the side that supplies operands and takes results.
// The slave modport is the converter itself.
interface hp_cvtws_seq_if #(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NEXP+NSIG:0]   in;
  logic                 out_valid;
  logic                 out_ready;
  logic [INTn-1:0]      out;
  logic                 inexact;
  logic                 invalid;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, inexact, invalid
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, inexact, invalid
  );
endinterface

// File: rtl/hp_cvtws_seq.sv
// Sequential bfloat16 -> signed INTn converter with round-to-nearest-even.
// The magnitude is shifted one bit per cycle; only one conversion is in flight.
// Optional macro CVT_FLAG_ACCUM_EN adds sticky accumulated flags (flag_clr,
// acc_inexact, acc_invalid) that update on every result handshake.
module hp_cvtws_seq #(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic clk,
  input  logic rst,
`ifdef CVT_FLAG_ACCUM_EN
  input  logic flag_clr,
  output logic acc_inexact,
  output logic acc_invalid,
`endif
  hp_cvtws_seq_if.slave bus
);

  localparam int FW   = NEXP + NSIG + 1;
  localparam int WW   = 2 * INTn;
  localparam int CW   = $clog2(WW);
  localparam int BIAS = (1 << (NEXP - 1)) - 1;

  localparam logic signed [NEXP+1:0] BIAS_S = (NEXP+2)'(BIAS);
  localparam logic signed [NEXP+1:0] LIM_S  = (NEXP+2)'(INTn - 1);
  localparam logic signed [NEXP+1:0] NSIG_S = (NEXP+2)'(NSIG);
  localparam logic signed [NEXP+1:0] NEG1_S = -(NEXP+2)'(1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CLASSIFY = 3'd1;
  localparam logic [2:0] SHIFT    = 3'd2;
  localparam logic [2:0] ROUND    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  // Round-to-nearest-even increment decision.
  function automatic logic round_up(input logic g, input logic s, input logic l);
    return g & (s | l);
  endfunction

  // Saturated result for an out-of-range or infinite operand of the given sign.
  function automatic logic [INTn-1:0] sat_val(input logic neg);
    return neg ? {1'b1, {(INTn-1){1'b0}}} : {1'b0, {(INTn-1){1'b1}}};
  endfunction

  // Two's-complement sign application at INTn bits.
  function automatic logic [INTn-1:0] apply_sign(input logic neg, input logic [INTn-1:0] mag);
    return neg ? -mag : mag;
  endfunction

  // Control state
  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic            out_valid_r;
  logic [INTn-1:0] out_r;
  logic            inexact_r;
  logic            invalid_r;

  // Datapath state (no reset needed; always loaded before use)
  logic            sgn;
  logic [NEXP-1:0] exp_r;
  logic [NSIG-1:0] man_r;
  logic [WW-1:0]   work;
  logic            guard;
  logic            sticky;
  logic            shl;
  logic            is_fixed;
  logic [INTn-1:0] fixed_res;
  logic            fixed_inx;
  logic            fixed_inv;

  // Classification results for the captured operand
  logic signed [NEXP+1:0] e_unb;
  logic                   cls_fixed;
  logic [INTn-1:0]        cls_res;
  logic                   cls_inx;
  logic                   cls_inv;
  logic                   cls_shl;
  logic [CW-1:0]          cls_k;
  logic [INTn-1:0]        rnd_mag;

  assign e_unb   = $signed({2'b00, exp_r}) - BIAS_S;
  assign rnd_mag = work[INTn-1:0] + {{(INTn-1){1'b0}}, round_up(guard, sticky, work[0])};

  // Decode operand class, fixed results and shift direction/count.
  always_comb begin
    cls_fixed = 1'b0;
    cls_res   = '0;
    cls_inx   = 1'b0;
    cls_inv   = 1'b0;
    cls_shl   = 1'b0;
    cls_k     = '0;
    if (&exp_r) begin
      cls_fixed = 1'b1;
      cls_inv   = 1'b1;
      cls_res   = (man_r != '0) ? sat_val(1'b0) : sat_val(sgn);
    end else if ((e_unb >= LIM_S) && !(sgn && (e_unb == LIM_S) && (man_r == '0))) begin
      cls_fixed = 1'b1;
      cls_inv   = 1'b1;
      cls_res   = sat_val(sgn);
    end else if ((exp_r == '0) || (e_unb < NEG1_S)) begin
      cls_fixed = 1'b1;
      cls_inx   = (exp_r != '0) || (man_r != '0);
    end else if (e_unb >= NSIG_S) begin
      cls_shl = 1'b1;
      cls_k   = CW'(e_unb - NSIG_S);
    end else begin
      cls_k   = CW'(NSIG_S - e_unb);
    end
  end

  // Operand capture, classification latch and the one-bit-per-cycle shifter.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sgn    <= bus.in[FW-1];
          exp_r  <= bus.in[FW-2:NSIG];
          man_r  <= bus.in[NSIG-1:0];
          work   <= {{(WW-NSIG-1){1'b0}}, 1'b1, bus.in[NSIG-1:0]};
          guard  <= 1'b0;
          sticky <= 1'b0;
        end
      end
      CLASSIFY: begin
        is_fixed  <= cls_fixed;
        fixed_res <= cls_res;
        fixed_inx <= cls_inx;
        fixed_inv <= cls_inv;
        shl       <= cls_shl;
      end
      SHIFT: begin
        if (shl) begin
          work <= work << 1;
        end else begin
          sticky <= sticky | guard;
          guard  <= work[0];
          work   <= work >> 1;
        end
      end
      default: ;
    endcase
  end

  // Sequencing, shift counter and the registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      inexact_r   <= 1'b0;
      invalid_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) state <= CLASSIFY;
        end
        CLASSIFY: begin
          cnt   <= cls_k;
          state <= (cls_fixed || (cls_k == '0)) ? ROUND : SHIFT;
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ROUND;
        end
        ROUND: begin
          out_valid_r <= 1'b1;
          if (is_fixed) begin
            out_r     <= fixed_res;
            inexact_r <= fixed_inx;
            invalid_r <= fixed_inv;
          end else begin
            out_r     <= apply_sign(sgn, rnd_mag);
            inexact_r <= guard | sticky;
            invalid_r <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.inexact   = inexact_r;
  assign bus.invalid   = invalid_r;

`ifdef CVT_FLAG_ACCUM_EN
  logic hs;
  assign hs = out_valid_r & bus.out_ready;

  // Sticky flag accumulation; a handshake in the clearing cycle still records.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_inexact <= 1'b0;
      acc_invalid <= 1'b0;
    end else begin
      acc_inexact <= (acc_inexact & ~flag_clr) | (hs & inexact_r);
      acc_invalid <= (acc_invalid & ~flag_clr) | (hs & invalid_r);
    end
  end
`endif

endmodule

// File: tb/tb_hp_cvtws_seq.sv
// Testbench for hp_cvtws_seq: vector table with a scoreboard queue,
// plus backpressure and mid-conversion reset sequences.
module tb_hp_cvtws_seq;

  logic clk;
  logic rst;
`ifdef CVT_FLAG_ACCUM_EN
  logic flag_clr;
  logic acc_inexact;
  logic acc_invalid;
`endif

  hp_cvtws_seq_if #(.INTn(32), .NEXP(8), .NSIG(7)) bif ();

  hp_cvtws_seq #(.INTn(32), .NEXP(8), .NSIG(7)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef CVT_FLAG_ACCUM_EN
    .flag_clr    (flag_clr),
    .acc_inexact (acc_inexact),
    .acc_invalid (acc_invalid),
`endif
    .bus         (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in;
    logic [31:0] out;
    logic        inx;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[18];
  vec_t sb[$];
  int   n_cmp;
  int   n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one operand, wait for its result and compare against the scoreboard.
  task automatic run_vec(input vec_t v);
    int   lat;
    int   w;
    vec_t e;
    string tag;
    tag = $sformatf("in=%h", v.in);
    w = 0;
    while (!bif.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, " in_ready"}, 32'(bif.in_ready), 32'd1);
    bif.in_valid = 1'b1;
    bif.in       = v.in;
    sb.push_back(v);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bif.out_valid && lat < 60);
    e = sb.pop_front();
    chk({tag, " out_valid"}, 32'(bif.out_valid), 32'd1);
    chk({tag, " out"}, bif.out, e.out);
    chk({tag, " inexact"}, 32'(bif.inexact), 32'(e.inx));
    chk({tag, " invalid"}, 32'(bif.invalid), 32'(e.inv));
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
  endtask

  initial begin
    vec_t v;
    int   seen;
    logic [31:0] held_out;

    n_cmp = 0;
    n_err = 0;
    vecs[0]  = '{16'h3F80, 32'h00000001, 1'b0, 1'b0,  9};
    vecs[1]  = '{16'h4020, 32'h00000002, 1'b1, 1'b0,  8};
    vecs[2]  = '{16'h4060, 32'h00000004, 1'b1, 1'b0,  8};
    vecs[3]  = '{16'h3F00, 32'h00000000, 1'b1, 1'b0, 10};
    vecs[4]  = '{16'hCF00, 32'h80000000, 1'b0, 1'b0, 26};
    vecs[5]  = '{16'h4F00, 32'h7FFFFFFF, 1'b0, 1'b1,  2};
    vecs[6]  = '{16'h7FC0, 32'h7FFFFFFF, 1'b0, 1'b1,  2};
    vecs[7]  = '{16'hFF80, 32'h80000000, 1'b0, 1'b1,  2};
    vecs[8]  = '{16'h0001, 32'h00000000, 1'b1, 1'b0,  2};
    vecs[9]  = '{16'h8000, 32'h00000000, 1'b0, 1'b0,  2};
    vecs[10] = '{16'hC0A0, 32'hFFFFFFFB, 1'b0, 1'b0,  7};
    vecs[11] = '{16'h3FC0, 32'h00000002, 1'b1, 1'b0,  9};
    vecs[12] = '{16'hBFC0, 32'hFFFFFFFE, 1'b1, 1'b0,  9};
    vecs[13] = '{16'h4B00, 32'h00800000, 1'b0, 1'b0, 18};
    vecs[14] = '{16'h3E80, 32'h00000000, 1'b1, 1'b0,  2};
    vecs[15] = '{16'h4300, 32'h00000080, 1'b0, 1'b0,  2};
    vecs[16] = '{16'h4EFF, 32'h7F800000, 1'b0, 1'b0, 25};
    vecs[17] = '{16'hCF01, 32'h80000000, 1'b0, 1'b1,  2};

    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in        = '0;
    bif.out_ready = 1'b1;
`ifdef CVT_FLAG_ACCUM_EN
    flag_clr      = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(bif.in_ready), 32'd0);
    chk("rst out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst out", bif.out, 32'd0);
    chk("rst inexact", 32'(bif.inexact), 32'd0);
    chk("rst invalid", 32'(bif.invalid), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle in_ready", 32'(bif.in_ready), 32'd1);

    // Vector table
    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // Backpressure: result and flags held, no new accept while stalled
    @(posedge clk); #1;
    bif.out_ready = 1'b0;
    run_vec(vecs[1]);
    held_out = bif.out;
    bif.in_valid = 1'b1;
    bif.in       = 16'h3F80;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d out", c), bif.out, 32'h00000002);
      chk($sformatf("bp%0d inexact", c), 32'(bif.inexact), 32'd1);
      chk($sformatf("bp%0d invalid", c), 32'(bif.invalid), 32'd0);
      chk($sformatf("bp%0d out_valid", c), 32'(bif.out_valid), 32'd1);
      chk($sformatf("bp%0d in_ready", c), 32'(bif.in_ready), 32'd0);
    end
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    chk("bp post in_ready", 32'(bif.in_ready), 32'd1);
    chk("bp post out_valid", 32'(bif.out_valid), 32'd0);
    chk("bp post out held", bif.out, held_out);

    // Reset during SHIFT discards the operation
    bif.in_valid = 1'b1;
    bif.in       = 16'h4B00;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst out_valid", 32'(bif.out_valid), 32'd0);
    chk("midrst in_ready low", 32'(bif.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst in_ready", 32'(bif.in_ready), 32'd1);
    chk("postrst out_valid", 32'(bif.out_valid), 32'd0);
    chk("postrst out", bif.out, 32'd0);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bif.out_valid) seen++;
    end
    chk("postrst no stray result", 32'(seen), 32'd0);
    v = '{16'hC0A0, 32'hFFFFFFFB, 1'b0, 1'b0, 7};
    run_vec(v);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hp_cvtws_seq.md
Name: hp_cvtws_seq

Overview:
Sequential bfloat16 → signed INTn converter. It is the inverse stage of the int-to-float converter and sits directly downstream of the FPU result bus, feeding the integer writeback path. It uses an iterative one-bit-per-cycle shifter with round-to-nearest-even, which matches the rounding of the float datapath. Valid/ready handshake on both sides; one conversion in flight at a time.

Parameters:
INTn, 32, integer result width
NEXP, 8, exponent width of float input
NSIG, 7, stored significand width of float input (hidden 1 not stored)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept operand
in  input  NEXP+NSIG+1  float operand {sign, exp, sig}
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  INTn  signed integer result
inexact  output  1  result not exactly representable; qualified by out_valid
invalid  output  1  NaN, infinity or out-of-range input; qualified by out_valid

Behaviour:
- Reset values: in_ready=0 during rst, then 1 in IDLE. out_valid=0, out=0, inexact=0, invalid=0, state=IDLE, shift counter=0.
- States: IDLE → CLASSIFY → SHIFT (k cycles, skipped if k=0) → ROUND → DONE → IDLE.
- in_ready = (state==IDLE). Accept on in_valid&in_ready: capture s, e, m; load sig={1,m} into a 2*INTn working register. Go to CLASSIFY.
- CLASSIFY (one cycle). Let E=e-BIAS, BIAS=2^(NEXP-1)-1:
  - e==all-ones, m≠0 (NaN): result 0x7FFFFFFF, invalid=1, k=0.
  - e==all-ones, m==0 (inf): result 0x7FFFFFFF (+) or 0x80000000 (−), invalid=1, k=0.
  - E ≥ INTn-1, except s=1, E=INTn-1, m=0: saturate by sign, invalid=1, k=0.
  - Exactly −2^(INTn-1): valid, result 0x80000000, left shift k=E-NSIG=24.
  - e==0 (zero or subnormal), or E < -1: result 0, inexact=(e|m)≠0, k=0.
  - E ≥ NSIG: left shift, k=E-NSIG.
  - -1 ≤ E < NSIG: right shift, k=NSIG-E (1..8).
- SHIFT: one bit per cycle; counter decrements, exit at 0. On right shift: sticky|=guard; guard=lsb out. Left shifts never lose bits.
- ROUND (one cycle): roundup = guard & (sticky | lsb). mag += roundup. Negate if s. inexact = guard|sticky for finite in-range inputs. Set out_valid=1, go to DONE.
- Latency: out_valid rises k+2 cycles after the accept edge, so specials and zero take 2 cycles and the worst case is 26 cycles.
- DONE: out, inexact and invalid are held stable while out_valid=1 and out_ready=0. On out_valid&out_ready: out_valid=0, state=IDLE. There is no same-cycle accept, so one bubble occurs between results. out and flags keep their last values after the handshake.
- in is ignored when in_ready=0. out_ready is ignored when out_valid=0.
- rst asserted in any state, including mid-SHIFT or DONE: return to reset values on that edge. The in-flight operation is discarded with no output.
- Width rules: rounding of a right-shifted ≤8-bit magnitude produces at most 256, so it never overflows. Negation uses INTn-bit two's complement.

Optional Feature:
CVT_FLAG_ACCUM_EN. When defined, the block adds input flag_clr (1) and outputs acc_inexact (1) and acc_invalid (1). These are sticky ORs of the flags, updated on each out handshake and cleared by rst or flag_clr. If flag_clr and a handshake occur in the same cycle, the new flags survive. When undefined, none of these ports or registers exist and behaviour is otherwise identical.

Test Plan:
- in=0x3F80 (1.0) → out=1, inexact=0, invalid=0, out_valid 9 cycles after accept (k=7).
- in=0x4020 (2.5) → out=2, inexact=1; in=0x4060 (3.5) → out=4, inexact=1; in=0x3F00 (0.5) → out=0, inexact=1 (tie to even).
- in=0xCF00 (−2^31) → out=0x80000000, invalid=0, latency 26. in=0x4F00 (+2^31) → out=0x7FFFFFFF, invalid=1, latency 2.
- in=0x7FC0 (NaN) → 0x7FFFFFFF, invalid=1. in=0xFF80 (−inf) → 0x80000000, invalid=1. in=0x0001 (subnormal) → 0, inexact=1. in=0x8000 → 0, no flags.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out and flags are stable and in_ready=0 throughout. In the cycle after the handshake, in_ready=1.
- Assert rst during SHIFT of 0x4B00 → next cycle out_valid=0, in_ready=1. A following 0xC0A0 (−5.0) → out=0xFFFFFFFB.
